// File: rtl/ovl_fabric_pkg.sv
// Shared types and default widths for the assertion-checker fabric.
package ovl_fabric_pkg;

  localparam int OVL_NUM_CHK    = 8;
  localparam int OVL_ID_WIDTH   = 3;
  localparam int OVL_TS_WIDTH   = 16;
  localparam int OVL_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    DRAIN    = 2'd2
  } ovl_state_e;

  // Event record field widths follow the fabric defaults; collector
  // instances must use matching ID_WIDTH/TS_WIDTH.
  typedef struct packed {
    logic [OVL_ID_WIDTH-1:0] id;
    logic [OVL_TS_WIDTH-1:0] ts;
  } ovl_evt_t;

endpackage

// File: rtl/ovl_fire_collector_if.sv
// Event record handshake toward the exception/debug unit.
interface ovl_fire_collector_if #(
  parameter int ID_WIDTH = 3,
  parameter int TS_WIDTH = 16
);
  logic                evt_valid;
  logic                evt_ready;
  logic [ID_WIDTH-1:0] evt_id;
  logic [TS_WIDTH-1:0] evt_ts;

  modport master (output evt_valid, output evt_id, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_ts, output evt_ready);
endinterface

// File: rtl/ovl_evt_fifo.sv
// Show-ahead event FIFO; the head record is presented whenever not empty.
module ovl_evt_fifo
  import ovl_fabric_pkg::*;
#(
  parameter int FIFO_DEPTH = OVL_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ovl_evt_t push_data,
  input  logic     pop,
  output ovl_evt_t head,
  output logic     full,
  output logic     empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  ovl_evt_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Full is taken from the registered count, so a same-cycle pop never
  // frees space for a push.
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards all entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage; contents are meaningless until counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects qualified checker fires into pending bits, arbitrates them into
// an event FIFO of {id, timestamp} records and keeps sticky status / irq.
module ovl_fire_collector
  import ovl_fabric_pkg::*;
#(
  parameter int NUM_CHK    = OVL_NUM_CHK,
  parameter int ID_WIDTH   = OVL_ID_WIDTH,
  parameter int TS_WIDTH   = OVL_TS_WIDTH,
  parameter int FIFO_DEPTH = OVL_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                config_invalid,
  input  logic [NUM_CHK-1:0]  fire_in,
  input  logic [NUM_CHK-1:0]  clear_sticky,
  ovl_fire_collector_if.master evt,
  output logic [NUM_CHK-1:0]  sticky,
  output logic                irq,
  output logic [7:0]          coalesce_cnt,
  output logic                busy
);

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {4'b0000, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  ovl_state_e          state;
  ovl_state_e          state_nxt;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [NUM_CHK-1:0]  pending;
  logic [NUM_CHK-1:0]  qf;
  logic [NUM_CHK-1:0]  push_mask;
  logic [NUM_CHK-1:0]  coal_hits;
  logic [ID_WIDTH-1:0] push_idx;
  logic [4:0]          coal_num;
  logic                push_any;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  ovl_evt_t            push_rec;
  ovl_evt_t            head_rec;

  assign qf        = (state == ARMED && !config_invalid) ? fire_in : '0;
  assign push      = push_any && !fifo_full;
  assign push_mask = push ? (NUM_CHK'(1) << push_idx) : '0;
  // A fire on the bit being pushed this cycle is a fresh event, not a merge.
  assign coal_hits = qf & pending & ~push_mask;
  assign push_rec  = '{id: push_idx, ts: ts_cnt};
  assign pop       = evt.evt_valid && evt.evt_ready;
  assign busy      = (state != DISABLED);

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_id    = head_rec.id;
  assign evt.evt_ts    = head_rec.ts;

  // Lowest-index pending bit wins the single push slot.
  always_comb begin
    push_any = 1'b0;
    push_idx = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_any = 1'b1;
        push_idx = ID_WIDTH'(i);
      end
    end
  end

  // Number of fires merged into already-pending bits this cycle.
  always_comb begin
    coal_num = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      coal_num = coal_num + {4'b0000, coal_hits[i]};
    end
  end

  // Collector mode: DRAIN keeps pushing pending bits until none remain.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DISABLED: if (enable) state_nxt = ARMED;
      ARMED:    if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)               state_nxt = ARMED;
        else if (pending == '0)   state_nxt = DISABLED;
      end
      default: state_nxt = DISABLED;
    endcase
  end

  // State register and free-running timestamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= DISABLED;
      ts_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  // Pending capture, sticky status, irq and coalesce counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= '0;
      sticky       <= '0;
      irq          <= 1'b0;
      coalesce_cnt <= '0;
    end else begin
      pending      <= (pending & ~push_mask) | qf;
      sticky       <= (sticky & ~clear_sticky) | qf;
      irq          <= |sticky;
      coalesce_cnt <= sat_add8(coalesce_cnt, coal_num);
    end
  end

  ovl_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed bench for ovl_fire_collector with a queue-based reference model.
module tb_ovl_fire_collector;
  import ovl_fabric_pkg::*;

  localparam int N = 8;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] ts;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         config_invalid = 1'b0;
  logic [N-1:0] fire_in = '0;
  logic [N-1:0] clear_sticky = '0;
  logic [N-1:0] sticky;
  logic         irq;
  logic         busy;
  logic [7:0]   coalesce_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  rec_t        m_q[$];
  logic [15:0] m_ts = '0;
  int          m_state = 0;   // 0 disabled, 1 armed, 2 drain
  logic [7:0]  m_pend = '0;
  logic [7:0]  m_sticky = '0;
  logic        m_irq = 1'b0;
  int          m_coal = 0;

  ovl_fire_collector_if #(.ID_WIDTH(3), .TS_WIDTH(16)) evt_bus ();

  ovl_fire_collector #(.NUM_CHK(N), .ID_WIDTH(3), .TS_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .config_invalid (config_invalid),
    .fire_in        (fire_in),
    .clear_sticky   (clear_sticky),
    .evt            (evt_bus),
    .sticky         (sticky),
    .irq            (irq),
    .coalesce_cnt   (coalesce_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ts = '0; m_state = 0; m_pend = '0; m_sticky = '0; m_irq = 1'b0; m_coal = 0;
  endtask

  // One clock of the behaviour rules, evaluated from pre-edge values.
  task automatic model_step();
    logic [7:0] qf, pend_old, st_old;
    bit   full, pop, push;
    int   idx;
    rec_t r;
    pend_old = m_pend;
    st_old   = m_sticky;
    qf   = (m_state == 1 && !config_invalid) ? fire_in : 8'h00;
    full = (m_q.size() == 4);
    pop  = (m_q.size() > 0) && evt_bus.evt_ready;
    push = 1'b0;
    idx  = 0;
    if (!full) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_old[i]) begin push = 1'b1; idx = i; break; end
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (qf[i] && pend_old[i] && !(push && idx == i) && m_coal < 255) m_coal++;
    end
    m_pend = pend_old;
    if (push) m_pend[idx] = 1'b0;
    m_pend = m_pend | qf;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      r.id = 3'(idx);
      r.ts = m_ts;
      m_q.push_back(r);
    end
    m_irq    = |st_old;
    m_sticky = (st_old & ~clear_sticky) | qf;
    case (m_state)
      0:       m_state = enable ? 1 : 0;
      1:       m_state = enable ? 1 : 2;
      default: m_state = enable ? 1 : ((pend_old == 8'h00) ? 0 : 2);
    endcase
    m_ts = m_ts + 16'd1;
  endtask

  task automatic compare_all();
    rec_t h;
    chk("evt_valid", {31'b0, evt_bus.evt_valid}, {31'b0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      h = m_q[0];
      chk("evt_id", {29'b0, evt_bus.evt_id}, {29'b0, h.id});
      chk("evt_ts", {16'b0, evt_bus.evt_ts}, {16'b0, h.ts});
    end
    chk("sticky", {24'b0, sticky}, {24'b0, m_sticky});
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("coalesce_cnt", {24'b0, coalesce_cnt}, 32'(m_coal));
    chk("busy", {31'b0, busy}, {31'b0, (m_state != 0)});
  endtask

  // Model advance and per-cycle comparison.
  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
    #1 compare_all();
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ts(input int n);
    int k;
    for (k = 0; k < 200; k++) begin
      if (m_ts == 16'(n)) break;
      tick();
    end
    if (k == 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ts: timestamp %0d not reached, at %0d", n, m_ts);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] got[$];
    logic [2:0]  exp_ids[6];
    int          k;
    exp_ids = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    evt_bus.evt_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_valid", {31'b0, evt_bus.evt_valid}, 0);
    chk("rst_id", {29'b0, evt_bus.evt_id}, 0);
    chk("rst_ts", {16'b0, evt_bus.evt_ts}, 0);
    chk("rst_sticky", {24'b0, sticky}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst = 1'b1;
    enable = 1'b1;
    evt_bus.evt_ready = 1'b1;

    // Basic event
    wait_ts(10);
    fire_in = 8'h01;
    tick();
    fire_in = 8'h00;
    chk("basic_sticky", {24'b0, sticky}, 32'h01);
    chk("basic_not_yet_valid", {31'b0, evt_bus.evt_valid}, 0);
    chk("basic_irq_lag", {31'b0, irq}, 0);
    tick();
    chk("basic_valid", {31'b0, evt_bus.evt_valid}, 1);
    chk("basic_id", {29'b0, evt_bus.evt_id}, 0);
    chk("basic_ts", {16'b0, evt_bus.evt_ts}, 11);
    chk("basic_irq", {31'b0, irq}, 1);

    // Priority
    wait_ts(30);
    fire_in = 8'h84;
    tick();
    fire_in = 8'h00;
    tick();
    chk("prio_id0", {29'b0, evt_bus.evt_id}, 2);
    chk("prio_ts0", {16'b0, evt_bus.evt_ts}, 31);
    tick();
    chk("prio_id1", {29'b0, evt_bus.evt_id}, 7);
    chk("prio_ts1", {16'b0, evt_bus.evt_ts}, 32);
    chk("prio_coal", {24'b0, coalesce_cnt}, 0);
    tick();
    chk("prio_empty", {31'b0, evt_bus.evt_valid}, 0);

    // Backpressure
    evt_bus.evt_ready = 1'b0;
    wait_ts(50);
    for (int i = 0; i < 6; i++) begin
      fire_in = 8'(1 << i);
      tick();
    end
    fire_in = 8'h10;
    tick();
    fire_in = 8'h00;
    tick();
    chk("bp_coal", {24'b0, coalesce_cnt}, 1);
    chk("bp_head_id", {29'b0, evt_bus.evt_id}, 0);
    chk("bp_head_ts", {16'b0, evt_bus.evt_ts}, 51);
    evt_bus.evt_ready = 1'b1;
    for (k = 0; k < 20 && got.size() < 6; k++) begin
      if (evt_bus.evt_valid) got.push_back({evt_bus.evt_id, evt_bus.evt_ts});
      tick();
    end
    chk("bp_count", 32'(got.size()), 6);
    for (int i = 0; i < got.size() && i < 6; i++) chk("bp_order", {29'b0, got[i][18:16]}, {29'b0, exp_ids[i]});
    if (got.size() >= 4) chk("bp_ts3", {16'b0, got[3][15:0]}, 54);

    // Masking
    clear_sticky = 8'hFF;
    tick();
    clear_sticky = 8'h00;
    evt_bus.evt_ready = 1'b0;
    fire_in = 8'h40;
    tick();
    fire_in = 8'h00;
    tick();
    config_invalid = 1'b1;
    fire_in = 8'hFF;
    tick();
    fire_in = 8'h00;
    config_invalid = 1'b0;
    repeat (2) tick();
    chk("mask_sticky", {24'b0, sticky}, 32'h40);
    chk("mask_head_id", {29'b0, evt_bus.evt_id}, 6);
    evt_bus.evt_ready = 1'b1;
    tick();
    chk("mask_drained", {31'b0, evt_bus.evt_valid}, 0);

    // Drain
    clear_sticky = 8'hFF;
    tick();
    clear_sticky = 8'h00;
    evt_bus.evt_ready = 1'b0;
    fire_in = 8'h3F;
    tick();
    fire_in = 8'h00;
    repeat (4) tick();
    enable = 1'b0;
    tick();
    chk("drain_busy_hold", {31'b0, busy}, 1);
    fire_in = 8'h80;
    tick();
    fire_in = 8'h00;
    repeat (2) tick();
    chk("drain_ignored", {24'b0, sticky}, 32'h3F);
    chk("drain_still_busy", {31'b0, busy}, 1);
    evt_bus.evt_ready = 1'b1;
    for (k = 0; k < 20 && busy; k++) tick();
    chk("drain_idle", {31'b0, busy}, 0);
    repeat (6) tick();
    chk("drain_empty", {31'b0, evt_bus.evt_valid}, 0);

    // Sticky set beats clear; asynchronous reset mid-queue
    enable = 1'b1;
    tick();
    clear_sticky = 8'h01;
    fire_in = 8'h01;
    tick();
    clear_sticky = 8'h00;
    fire_in = 8'h00;
    chk("sticky_set_wins", {31'b0, sticky[0]}, 1);
    evt_bus.evt_ready = 1'b0;
    fire_in = 8'h06;
    tick();
    fire_in = 8'h00;
    repeat (2) tick();
    chk("pre_rst_valid", {31'b0, evt_bus.evt_valid}, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, evt_bus.evt_valid}, 0);
    chk("arst_id", {29'b0, evt_bus.evt_id}, 0);
    chk("arst_sticky", {24'b0, sticky}, 0);
    chk("arst_irq", {31'b0, irq}, 0);
    chk("arst_coal", {24'b0, coalesce_cnt}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    tick();
    rst = 1'b1;
    enable = 1'b0;
    evt_bus.evt_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_empty", {31'b0, evt_bus.evt_valid}, 0);
    chk("post_rst_sticky", {24'b0, sticky}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ovl_fire_collector.md
Name: ovl_fire_collector

Overview:
Consumer end of the assertion-checker fabric. Samples the per-checker fire outputs, which are already gated by configuration validity, and coalesces them into per-checker pending bits. Arbitrates the pending bits into a small event FIFO as {checker id, timestamp} records and drains them to the exception/debug unit over a valid/ready handshake. Also keeps sticky per-checker status and an interrupt line.

Parameters:
NUM_CHK, 8, number of checker fire inputs (2..16)
ID_WIDTH, 3, width of checker id; equals clog2(NUM_CHK)
TS_WIDTH, 16, free-running timestamp width
FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-low reset
enable  in  1  capture enable from fabric config
config_invalid  in  1  high while checker config is being rewritten; masks all fire_in
fire_in  in  NUM_CHK  per-checker fire pulses; active-high, one bit per checker
clear_sticky  in  NUM_CHK  one-cycle clear mask for sticky bits
evt_valid  out  1  event record available
evt_ready  in  1  consumer accepts the record
evt_id  out  ID_WIDTH  checker index of the head record
evt_ts  out  TS_WIDTH  timestamp of the head record
sticky  out  NUM_CHK  per-checker "has fired" status
irq  out  1  equals OR of all sticky bits
coalesce_cnt  out  8  saturating count of fires merged into an already-pending bit
busy  out  1  high when state is not DISABLED

Behaviour:
- Reset (rst=0, asynchronous): state=DISABLED; pending=0; FIFO empty; ts_cnt=0; all outputs 0.
- ts_cnt increments every clock after reset and wraps modulo 2^TS_WIDTH.
- Qualified fire: qf = fire_in & {NUM_CHK{~config_invalid}}, accepted only in state ARMED.
- FSM:
  - DISABLED -> ARMED when enable=1.
  - ARMED -> DRAIN when enable=0.
  - DRAIN -> DISABLED when pending==0.
  - DRAIN -> ARMED when enable=1 again; pending is kept.
  - No captures happen in DRAIN or DISABLED. Pushes from pending continue in DRAIN.
- Capture: at each edge, pending |= qf and sticky |= qf.
  - If qf[i]=1 while pending[i] is already 1 and bit i is not pushed this cycle, coalesce_cnt += 1. It saturates at 255 and is cleared only by reset.
- Arbitration: each cycle, the lowest index i with pending[i]=1 is pushed if the FIFO is not full.
  - The record written is {i, ts_cnt of the current cycle}, and pending[i] is cleared.
  - If qf[i]=1 in the same cycle, pending[i] stays set (a new event, not a coalesce).
  - At most one push per cycle.
- Latency: a fire sampled at edge t becomes pending. With the FIFO empty and no lower index pending, it is pushed in the cycle after t and evt_valid rises at the following edge. That is 2 edges from the fire cycle to evt_valid.
- FIFO:
  - Show-ahead: evt_id/evt_ts hold the head record whenever evt_valid=1.
  - A pop occurs when evt_valid && evt_ready.
  - A push is blocked when the registered count == FIFO_DEPTH, even if a pop happens in the same cycle. Pending bits hold the events, so nothing is lost.
  - Head outputs are stable while evt_valid=1 and evt_ready=0.
  - Push and pop may occur in the same cycle when not full.
- Sticky:
  - sticky[i] is cleared when clear_sticky[i]=1.
  - A set in the same cycle wins.
  - irq is the registered OR of sticky.
- config_invalid only masks new fires. Pending bits, FIFO contents and sticky are untouched.
- Reset asserted mid-operation discards pending, FIFO contents and sticky immediately.

Decomposition:
- Package ovl_fabric_pkg holds:
  - typedef enum for the collector state {DISABLED, ARMED, DRAIN}
  - a packed struct ovl_evt_t {id, ts}
  - default widths as constants
- One natural sub-module, ovl_evt_fifo. It is a synchronous show-ahead FIFO of ovl_evt_t with push/pop/full/empty/count and the same clk/rst. The arbiter, pending logic and FSM stay in the top module.

Test Plan:
- Basic event: reset, enable=1, evt_ready=1; pulse fire_in=0x01 in the cycle where ts_cnt=10 -> evt_valid at the edge ending ts_cnt=11 with evt_id=0, evt_ts=11; sticky=0x01; irq=1 one edge later.
- Priority: fire_in=0x84 in one cycle -> records id=2 (ts=n+1) then id=7 (ts=n+2); coalesce_cnt=0.
- Backpressure: evt_ready=0; fire ids 0..5 one per cycle -> 4 records queued (ids 0..3), pending=0x30. Refire id 4 -> coalesce_cnt=1. Raise evt_ready -> ids 0,1,2,3,4,5 delivered in order; no loss.
- Masking: config_invalid=1 with fire_in=0xFF -> no pending, no sticky, no records; an already queued record still drains.
- Drain: leave 2 pending bits, drop enable -> busy stays 1 until both are pushed, then state DISABLED and busy=0. A fire during DRAIN is ignored.
- Sticky and reset: clear_sticky=0x01 together with fire_in=0x01 -> sticky[0] stays 1. Assert rst mid-queue -> all outputs 0 asynchronously, FIFO empty after release.
